// File: rtl/master_port.sv
// rtl/master_port.sv - bus master port: turns a device request into an arbitrated serial bus transaction
// Address and write data go out LSB first; read data is assembled from the slave's serial stream.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  dready,
  output logic                  ack,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, RDATA, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   addr_sh;
  logic [DATA_WIDTH-1:0]   wdata_sh;
  logic [DATA_WIDTH-1:0]   rdata_sh;
  logic                    mode_q;

  assign dready = (state == IDLE);

  // Outputs are loaded on the edge that enters each state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_sh  <= '0;
      wdata_sh <= '0;
      rdata_sh <= '0;
      mode_q   <= 1'b0;
      drdata   <= '0;
      ack      <= 1'b0;
      mbreq    <= 1'b0;
      mwdata   <= 1'b0;
      mmode    <= 1'b0;
      mvalid   <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dvalid) begin
            addr_sh  <= daddr;
            wdata_sh <= dwdata;
            mode_q   <= dmode;
            mbreq    <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mbgrant && sready) begin
            state   <= ADDR;
            cnt     <= '0;
            mvalid  <= 1'b1;
            mmode   <= mode_q;
            mwdata  <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
          end
        end
        ADDR: begin
          if (cnt == A_LAST) begin
            cnt <= '0;
            if (mode_q) begin
              state    <= WDATA;
              mwdata   <= wdata_sh[0];
              wdata_sh <= wdata_sh >> 1;
            end else begin
              state  <= RDATA;
              mvalid <= 1'b0;
              mwdata <= 1'b0;
            end
          end else begin
            cnt     <= cnt + CW'(1);
            mwdata  <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
          end
        end
        WDATA: begin
          if (cnt == D_LAST) begin
            cnt    <= '0;
            state  <= DONE;
            mvalid <= 1'b0;
            mwdata <= 1'b0;
            mbreq  <= 1'b0;
            ack    <= 1'b1;
          end else begin
            cnt      <= cnt + CW'(1);
            mwdata   <= wdata_sh[0];
            wdata_sh <= wdata_sh >> 1;
          end
        end
        RDATA: begin
          // Bits shift in from the top so the first (LSB) bit lands at index 0 after the last one.
          if (svalid) begin
            rdata_sh <= {srdata, rdata_sh[DATA_WIDTH-1:1]};
            if (cnt == D_LAST) begin
              cnt    <= '0;
              drdata <= {srdata, rdata_sh[DATA_WIDTH-1:1]};
              state  <= DONE;
              mbreq  <= 1'b0;
              ack    <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - randomized scoreboard bench for master_port
// Driver pushes expected serial beats and completions; a monitor pops and compares them.
module tb_master_port;

  logic        clk;
  logic        rstn;
  logic        dvalid;
  logic        dmode;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic [7:0]  drdata;
  logic        dready;
  logic        ack;
  logic        mbreq;
  logic        mbgrant;
  logic        mwdata;
  logic        mmode;
  logic        mvalid;
  logic        srdata;
  logic        svalid;
  logic        sready;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata), .dready(dready), .ack(ack), .mbreq(mbreq),
    .mbgrant(mbgrant), .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .srdata(srdata), .svalid(svalid), .sready(sready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit timed = 1'b0;
  logic [7:0] ref_drdata = 8'h00;
  logic [1:0] exp_bits[$];   // {mode, bit}
  logic [8:0] exp_ack[$];    // {mode, drdata}
  logic       prev_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-exact expectations for a write with grant and sready tied high, cycle 0 = request edge.
  task automatic chk_timing();
    logic [3:0] e;
    e = {(cyc >= 1 && cyc <= 21), (cyc >= 2 && cyc <= 21), (cyc == 22), (cyc == 0 || cyc >= 23)};
    chk($sformatf("timing_c%0d", cyc), 32'({mbreq, mvalid, ack, dready}), 32'(e));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (timed) chk_timing();
  endtask

  // Monitor: every qualified beat and every completion is checked against the queues.
  initial begin
    logic [1:0] eb;
    logic [8:0] ea;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (mvalid) begin
          chk("beat_expected", 32'(exp_bits.size() > 0), 32'd1);
          if (exp_bits.size() > 0) begin
            eb = exp_bits.pop_front();
            chk("beat", 32'({mmode, mwdata}), 32'(eb));
          end
        end
        if (ack) begin
          chk("ack_single_cycle", 32'(prev_ack), 32'd0);
          chk("ack_expected", 32'(exp_ack.size() > 0), 32'd1);
          if (exp_ack.size() > 0) begin
            ea = exp_ack.pop_front();
            chk("ack_drdata", 32'(drdata), 32'(ea[7:0]));
            chk("ack_quiet_mode", 32'({mvalid, mbreq, mmode}), 32'({2'b00, ea[8]}));
          end
        end
        prev_ack = ack;
      end else begin
        prev_ack = 1'b0;
      end
    end
  end

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("reset_async", 32'({mvalid, mbreq, dready, ack, mmode, mwdata}), 32'(6'b001000));
    chk("reset_drdata", 32'(drdata), 32'd0);
    exp_bits.delete();
    exp_ack.delete();
    ref_drdata = 8'h00;
    dvalid = 1'b0; svalid = 1'b0; srdata = 1'b0; mbgrant = 1'b1; sready = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_txn(input bit mode, input logic [11:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input int gdelay, input bit rnd_hold,
                         input bit busy, input bit spurious, input bit drop_grant,
                         input bit rnd_gaps, input int gap_at, input int gap_len, input int rst_at);
    int g;
    int n;
    chk("idle_ready", 32'(dready), 32'd1);
    cyc = 0;
    dvalid = 1'b1; dmode = mode; daddr = a; dwdata = wd;
    for (int i = 0; i < 12; i++) exp_bits.push_back({mode, a[i]});
    if (mode) for (int i = 0; i < 8; i++) exp_bits.push_back({1'b1, wd[i]});
    exp_ack.push_back({mode, mode ? ref_drdata : rd});
    if (!mode) ref_drdata = rd;
    if (gdelay == 0) begin
      mbgrant = 1'b1; sready = 1'b1;
    end else if (rnd_hold) begin
      n = int'($urandom_range(0, 2));
      {mbgrant, sready} = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b10;
    end else begin
      mbgrant = 1'b0; sready = 1'b1;
    end
    g = (gdelay < 1) ? 1 : gdelay;
    tick();
    dvalid = 1'b0; daddr = 12'($urandom); dwdata = 8'($urandom);
    for (int k = 1; k <= g; k++) begin
      chk("req_hold", 32'({mbreq, mvalid}), 32'(2'b10));
      if (k == g) begin
        mbgrant = 1'b1; sready = 1'b1;
      end else if (rnd_hold) begin
        n = int'($urandom_range(0, 2));
        {mbgrant, sready} = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b10;
      end
      tick();
    end
    chk("addr_start", 32'(mvalid), 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (busy && i < 3) begin
        dvalid = 1'b1; dmode = ~mode; daddr = 12'($urandom); dwdata = 8'($urandom);
      end else begin
        dvalid = 1'b0;
      end
      if (drop_grant && i == 1) begin
        mbgrant = 1'b0; sready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    dvalid = 1'b0;
    if (mode) begin
      if (spurious) begin
        for (int i = 0; i < 8; i++) begin
          svalid = 1'b1; srdata = 1'($urandom);
          tick();
        end
        svalid = 1'b0;
      end
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (b == gap_at) n = gap_len;
        else n = rnd_gaps ? int'($urandom_range(0, 2)) : 0;
        svalid = 1'b0;
        repeat (n) tick();
        svalid = 1'b1; srdata = rd[b];
        tick();
      end
      svalid = 1'b0; srdata = 1'b0;
      chk("read_ack_after_last_bit", 32'(ack), 32'd1);
    end
    n = 0;
    while (!dready && n < 100) begin
      tick();
      n++;
    end
    chk("done_in_time", 32'(dready), 32'd1);
    mbgrant = 1'b1; sready = 1'b1;
    tick();
    chk("no_ghost_request", 32'({mbreq, dready}), 32'(2'b01));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
    mbgrant = 1'b1; sready = 1'b1; svalid = 1'b0; srdata = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({dready, mbreq, mvalid, ack, mmode, mwdata}), 32'(6'b100000));
    chk("reset_drdata_init", 32'(drdata), 32'd0);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Write with grant tied high, cycle exact
    timed = 1'b1;
    run_txn(1'b1, 12'hA5C, 8'h3B, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
    timed = 1'b0;

    // Read with a 2-cycle svalid gap between bits 3 and 4
    run_txn(1'b0, 12'h001, 8'h00, 8'hC6, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 2, -1);
    chk("read_result", 32'(drdata), 32'h0C6);

    // Grant withheld for 10 cycles
    run_txn(1'b1, 12'h3F1, 8'h96, 8'h00, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);

    // Competing request during the address phase
    run_txn(1'b1, 12'h7E2, 8'h5A, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0, -1);

    // Spurious svalid during write data
    run_txn(1'b1, 12'h10F, 8'hE4, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, -1);
    chk("drdata_hold_spurious", 32'(drdata), 32'h0C6);

    // Reset at address bit 5, then the reference write again
    run_txn(1'b1, 12'hA5C, 8'h3B, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 5);
    timed = 1'b1;
    run_txn(1'b1, 12'hA5C, 8'h3B, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
    timed = 1'b0;

    for (int t = 0; t < 30; t++) begin
      run_txn(1'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 4)), 1'b1, 1'($urandom), 1'($urandom),
              1'($urandom), 1'b1, -1, 0, -1);
      chk("drdata_model", 32'(drdata), 32'(ref_drdata));
    end

    repeat (3) @(negedge clk);
    chk("beats_drained", 32'(exp_bits.size()), 32'd0);
    chk("acks_drained", 32'(exp_ack.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 dvalid  input  1  SHALL indicate a device transaction request.
REQ-006 dmode  input  1  SHALL select the transaction type: 0 read, 1 write.
REQ-007 daddr  input  ADDR_WIDTH  SHALL carry the target address.
REQ-008 dwdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-009 drdata  output  DATA_WIDTH  SHALL hold the last completed read data.
REQ-010 dready  output  1  SHALL be high when the port can accept a request.
REQ-011 ack  output  1  SHALL pulse high for one cycle at transaction completion.
REQ-012 mbreq  output  1  SHALL request the bus from the arbiter.
REQ-013 mbgrant  input  1  SHALL indicate the bus is granted to this port.
REQ-014 mwdata  output  1  SHALL carry serial address/write data to the slave, LSB first.
REQ-015 mmode  output  1  SHALL carry the transaction type to the slave (0 read, 1 write).
REQ-016 mvalid  output  1  SHALL qualify mwdata.
REQ-017 srdata  input  1  SHALL carry serial read data from the slave, LSB first.
REQ-018 svalid  input  1  SHALL qualify srdata.
REQ-019 sready  input  1  SHALL indicate the slave is idle and ready.

Function
REQ-020 States SHALL be IDLE, REQ, ADDR, WDATA, RDATA and DONE; all outputs except dready SHALL be registered.
REQ-021 dready SHALL equal (state == IDLE).
REQ-022 IDLE: if dvalid=1, the block SHALL latch daddr, dwdata and dmode, go to REQ, and drive mbreq=1 from the next cycle; dvalid in any other state SHALL be ignored.
REQ-023 REQ: hold mbreq=1 and mvalid=0; when mbgrant=1 and sready=1 are sampled, go to ADDR.
REQ-024 ADDR: for exactly ADDR_WIDTH consecutive cycles, drive mvalid=1, mmode=latched mode, and mwdata=addr[i] for i=0..ADDR_WIDTH-1.
REQ-025 After ADDR, the next state SHALL be WDATA if mode=1, otherwise RDATA.
REQ-026 WDATA: for exactly DATA_WIDTH cycles immediately following the last address bit, drive mvalid=1 and mwdata=wdata[i], LSB first; then go to DONE.
REQ-027 RDATA: drive mvalid=0; on each cycle with svalid=1, write srdata into rdata[count] and increment count; after DATA_WIDTH captured bits, go to DONE. Cycles with svalid=0 SHALL not advance count.
REQ-028 svalid/srdata SHALL be ignored outside RDATA.
REQ-029 DONE: one cycle with ack=1, mbreq=0 and mvalid=0; for reads, drdata SHALL be updated with the assembled word in this same cycle; then go to IDLE.
REQ-030 mmode SHALL remain stable from the first ADDR cycle through DONE.
REQ-031 Once mbgrant is sampled in REQ, loss of mbgrant SHALL be ignored until DONE.
REQ-032 The bit counter SHALL be wide enough for max(ADDR_WIDTH, DATA_WIDTH), SHALL clear on every state entry, and SHALL never wrap mid-phase.
REQ-033 drdata SHALL hold its value through write transactions and idle periods.

Reset
REQ-034 On rstn=0, at any time including mid-transaction, the block SHALL immediately enter IDLE, drive mbreq=0, mvalid=0, mwdata=0, mmode=0, ack=0 and drdata=0, and discard latched request data.
REQ-035 After rstn is released, the first possible request acceptance SHALL occur on the first rising edge with dvalid=1.

Verification (ADDR_WIDTH=12, DATA_WIDTH=8)
REQ-036 The bench SHALL cover a write with mbgrant=sready=1 tied high.
- Stimulus: dvalid pulse at edge 0 with daddr=0xA5C, dwdata=0x3B, dmode=1.
- Required response: mbreq=1 from cycle 1; mvalid=1 in cycles 2-21 carrying bits 0,0,1,1,1,0,1,0,0,1,0,1 then 1,1,0,1,1,1,0,0; ack=1 with mvalid=0 in cycle 22; dready=1 in cycle 23.
REQ-037 The bench SHALL cover a read with slave model gaps.
- Stimulus: daddr=0x001, dmode=0; slave returns 0xC6 with svalid low 2 cycles between bits 3 and 4.
- Required response: drdata=0xC6 and a single-cycle ack after the 8th valid bit; mvalid=0 after the address phase.
REQ-038 The bench SHALL cover a grant delay.
- Stimulus: mbgrant held low for 10 cycles.
- Required response: mbreq=1 and mvalid=0 throughout; the address phase starts the cycle after mbgrant=1 is sampled.
REQ-039 The bench SHALL cover a busy request.
- Stimulus: dvalid asserted with different data during ADDR.
- Required response: the request is ignored; the original transaction completes unchanged.
REQ-040 The bench SHALL cover reset during a write.
- Stimulus: rstn pulled low in address bit 5.
- Required response: mvalid=0, mbreq=0 and dready=1 without waiting for a clock edge; the next request behaves per REQ-036.
REQ-041 The bench SHALL cover spurious svalid.
- Stimulus: svalid=1 during WDATA.
- Required response: drdata is unchanged.
